ps2_controller: RTL and testbench

- Host-side PS/2 port controller: receives bytes framed by the device and transmits one-byte commands using the PS/2 host-to-device protocol.
- Sits between a peripheral register block (e.g. a mouse device) and the open-drain PS2_CLK/PS2_DAT pad pair.
- Delivers each received byte with a one-cycle strobe.
- Reports command completion or timeout as levels that are held until the request is dropped.

---
 rtl/ps2_controller.sv | 222 ++++++++++++++++++++++
 tb/tb_ps2_controller.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_controller.sv
// Host-side PS/2 controller: receives device frames and sends one-byte host-to-device commands.
// Build option: define PS2_PARITY_CHECK_EN to drop received frames with bad odd parity or stop bit.
module ps2_controller #(
  parameter int INHIBIT_CYCLES          = 5000,
  parameter int START_TIMEOUT_CYCLES    = 750000,
  parameter int XFER_TIMEOUT_CYCLES     = 100000,
  parameter int RX_FRAME_TIMEOUT_CYCLES = 10000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] the_command,
  input  logic       send_command,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT,
  output logic [7:0] received_data,
  output logic       received_data_en,
  output logic       command_was_sent,
  output logic       error_communication_timed_out
);

  localparam int TX_MAX_A = (INHIBIT_CYCLES > START_TIMEOUT_CYCLES) ? INHIBIT_CYCLES : START_TIMEOUT_CYCLES;
  localparam int TX_MAX   = (TX_MAX_A > XFER_TIMEOUT_CYCLES) ? TX_MAX_A : XFER_TIMEOUT_CYCLES;
  localparam int TX_CW    = $clog2(TX_MAX + 1);
  localparam int RX_CW    = $clog2(RX_FRAME_TIMEOUT_CYCLES + 1);

  localparam logic [TX_CW-1:0] INHIBIT_LAST = TX_CW'(INHIBIT_CYCLES - 1);
  localparam logic [TX_CW-1:0] START_LAST   = TX_CW'(START_TIMEOUT_CYCLES - 1);
  localparam logic [TX_CW-1:0] XFER_LAST    = TX_CW'(XFER_TIMEOUT_CYCLES - 1);
  localparam logic [RX_CW-1:0] RX_TO_LAST   = RX_CW'(RX_FRAME_TIMEOUT_CYCLES - 1);

  localparam logic [1:0] RX_IDLE = 2'd0;
  localparam logic [1:0] RX_BITS = 2'd1;
  localparam logic [1:0] RX_DONE = 2'd2;

  localparam logic [2:0] TX_IDLE       = 3'd0;
  localparam logic [2:0] TX_INHIBIT    = 3'd1;
  localparam logic [2:0] TX_RTS        = 3'd2;
  localparam logic [2:0] TX_WAIT_START = 3'd3;
  localparam logic [2:0] TX_BITS       = 3'd4;
  localparam logic [2:0] TX_ACK        = 3'd5;
  localparam logic [2:0] TX_DONE       = 3'd6;

  logic [2:0]       clk_sync;
  logic [1:0]       dat_sync;
  logic             clk_fall;
  logic             dat_bit;

  logic [1:0]       rx_state;
  logic [3:0]       rx_count;
  logic [9:0]       rx_shift;
  logic [RX_CW-1:0] rx_timer;
  logic             rx_enable;
  logic             frame_ok;

  logic [2:0]       tx_state;
  logic [TX_CW-1:0] tx_count;
  logic [8:0]       tx_shift;
  logic [3:0]       tx_idx;
  logic             dat_low_bit;
  logic             send_prev;
  logic             send_rise;
  logic             tx_pending;
  logic             clk_low;
  logic             dat_low;

  // Open-drain pads: only ever pull low or float.
  assign PS2_CLK = clk_low ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_low ? 1'b0 : 1'bz;

  assign clk_low = (tx_state == TX_INHIBIT) || (tx_state == TX_RTS);
  assign dat_low = (tx_state == TX_RTS) || (tx_state == TX_WAIT_START) || dat_low_bit;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      clk_sync <= 3'b111;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[1:0], PS2_CLK};
      dat_sync <= {dat_sync[0], PS2_DAT};
    end
  end

  assign clk_fall  = clk_sync[2] & ~clk_sync[1];
  assign dat_bit   = dat_sync[1];
  assign rx_enable = (tx_state == TX_IDLE) || (tx_state == TX_DONE);
  assign send_rise = send_command & ~send_prev;

`ifdef PS2_PARITY_CHECK_EN
  assign frame_ok = (^rx_shift[8:0]) & rx_shift[9];
`else
  logic unused_frame_bits;
  assign unused_frame_bits = ^rx_shift[9:8];
  assign frame_ok = 1'b1;
`endif

  // Receive: rx_shift collects data0..7, parity, stop; data lands in [7:0].
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      rx_state         <= RX_IDLE;
      rx_count         <= 4'd0;
      rx_shift         <= 10'd0;
      rx_timer         <= '0;
      received_data    <= 8'd0;
      received_data_en <= 1'b0;
    end else begin
      received_data_en <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          rx_count <= 4'd0;
          rx_timer <= '0;
          if (rx_enable && clk_fall && !dat_bit) rx_state <= RX_BITS;
        end
        RX_BITS: begin
          if (clk_fall) begin
            rx_shift <= {dat_bit, rx_shift[9:1]};
            rx_timer <= '0;
            rx_count <= rx_count + 4'd1;
            if (rx_count == 4'd9) rx_state <= RX_DONE;
          end else if (rx_timer == RX_TO_LAST) begin
            rx_state <= RX_IDLE;
          end else begin
            rx_timer <= rx_timer + 1'b1;
          end
        end
        RX_DONE: begin
          rx_state <= RX_IDLE;
          if (frame_ok) begin
            received_data    <= rx_shift[7:0];
            received_data_en <= 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Transmit: tx_shift holds {parity, data}; each device falling edge presents bit [0] and shifts.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      tx_state                      <= TX_IDLE;
      tx_count                      <= '0;
      tx_shift                      <= 9'd0;
      tx_idx                        <= 4'd0;
      dat_low_bit                   <= 1'b0;
      send_prev                     <= 1'b0;
      tx_pending                    <= 1'b0;
      command_was_sent              <= 1'b0;
      error_communication_timed_out <= 1'b0;
    end else begin
      send_prev <= send_command;
      case (tx_state)
        TX_IDLE: begin
          tx_count <= '0;
          if (send_rise) tx_shift <= {~^the_command, the_command};
          if ((send_rise || tx_pending) && (rx_state == RX_IDLE)) begin
            tx_pending <= 1'b0;
            tx_state   <= TX_INHIBIT;
          end else if (send_rise) begin
            tx_pending <= 1'b1;
          end
        end
        TX_INHIBIT: begin
          if (tx_count == INHIBIT_LAST) begin
            tx_count <= '0;
            tx_state <= TX_RTS;
          end else begin
            tx_count <= tx_count + 1'b1;
          end
        end
        TX_RTS: begin
          tx_count <= '0;
          tx_state <= TX_WAIT_START;
        end
        TX_WAIT_START: begin
          if (clk_fall) begin
            dat_low_bit <= ~tx_shift[0];
            tx_shift    <= {1'b1, tx_shift[8:1]};
            tx_idx      <= 4'd1;
            tx_count    <= '0;
            tx_state    <= TX_BITS;
          end else if (tx_count == START_LAST) begin
            error_communication_timed_out <= 1'b1;
            tx_state                      <= TX_DONE;
          end else begin
            tx_count <= tx_count + 1'b1;
          end
        end
        TX_BITS, TX_ACK: begin
          if (tx_count == XFER_LAST) begin
            dat_low_bit                   <= 1'b0;
            error_communication_timed_out <= 1'b1;
            tx_state                      <= TX_DONE;
          end else begin
            tx_count <= tx_count + 1'b1;
            if (clk_fall && (tx_state == TX_ACK)) begin
              if (!dat_bit) command_was_sent <= 1'b1;
              else error_communication_timed_out <= 1'b1;
              tx_state <= TX_DONE;
            end else if (clk_fall && (tx_idx == 4'd9)) begin
              dat_low_bit <= 1'b0;
              tx_state    <= TX_ACK;
            end else if (clk_fall) begin
              dat_low_bit <= ~tx_shift[0];
              tx_shift    <= {1'b1, tx_shift[8:1]};
              tx_idx      <= tx_idx + 4'd1;
            end
          end
        end
        TX_DONE: begin
          dat_low_bit <= 1'b0;
          if (!send_command) begin
            command_was_sent              <= 1'b0;
            error_communication_timed_out <= 1'b0;
            tx_state                      <= TX_IDLE;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_controller.sv
// Bench for ps2_controller: PS/2 device model, receive scoreboard and host-to-device frame checks.
module tb_ps2_controller;
  localparam int INH      = 40;
  localparam int START_TO = 1000;
  localparam int XFER_TO  = 2000;
  localparam int RX_TO    = 200;
  localparam int H        = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] the_command;
  logic       send_command;
  logic       dev_clk_low;
  logic       dev_dat_low;
  wire        ps2_clk;
  wire        ps2_dat;
  logic [7:0] received_data;
  logic       received_data_en;
  logic       command_was_sent;
  logic       error_communication_timed_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [9:0] exp_tx_q[$];
  logic [7:0] last_rx = 8'd0;

  assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
  assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;
  pullup (ps2_clk);
  pullup (ps2_dat);

  ps2_controller #(
    .INHIBIT_CYCLES(INH),
    .START_TIMEOUT_CYCLES(START_TO),
    .XFER_TIMEOUT_CYCLES(XFER_TO),
    .RX_FRAME_TIMEOUT_CYCLES(RX_TO)
  ) dut (
    .CLOCK_50(clk),
    .reset(rst),
    .the_command(the_command),
    .send_command(send_command),
    .PS2_CLK(ps2_clk),
    .PS2_DAT(ps2_dat),
    .received_data(received_data),
    .received_data_en(received_data_en),
    .command_was_sent(command_was_sent),
    .error_communication_timed_out(error_communication_timed_out)
  );

  // Clock / watchdog
  always #10 clk = ~clk;

  initial begin
    #1200000;
    $display("FAIL watchdog: simulation still running after 60000 cycles, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Receive monitor: every strobe must match the oldest expected byte
  always @(negedge clk) begin
    if (rst === 1'b0 && received_data_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rx_unexpected_pulse: got %0h expected no pulse", received_data);
      end else begin
        check("rx_byte", {24'd0, received_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // Device-to-host: drive nbits of frame (LSB first), data changes while clock is high
  task automatic dev_frame(input logic [10:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      dev_dat_low = ~frame[i];
      cyc(H / 2);
      dev_clk_low = 1'b1;
      cyc(H);
      dev_clk_low = 1'b0;
      cyc(H / 2);
    end
    dev_dat_low = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] d, input logic par, input logic stp);
    logic deliver;
`ifdef PS2_PARITY_CHECK_EN
    deliver = (($countones({d, par}) % 2) == 1) && stp;
`else
    deliver = 1'b1;
`endif
    if (deliver) begin
      exp_q.push_back(d);
      last_rx = d;
    end
    dev_frame({stp, par, d, 1'b0}, 11);
    cyc(10);
    check("rx_hold", {24'd0, received_data}, {24'd0, last_rx});
  endtask

  // Host-to-device: observe inhibit + request-to-send, then clock n_clocks edges (11 = full + ack)
  task automatic dev_host_rx(input int n_clocks, output logic [9:0] bits, output int inh_len);
    int t;
    bits    = 10'd0;
    inh_len = 0;
    t = 0;
    while (ps2_clk !== 1'b0 && t < 5000) begin cyc(1); t++; end
    if (t >= 5000) begin
      check("tx_inhibit_seen", 0, 1);
      return;
    end
    while (ps2_clk === 1'b0 && ps2_dat !== 1'b0 && t < 5000) begin cyc(1); t++; inh_len++; end
    while (ps2_clk === 1'b0 && t < 5000) begin cyc(1); t++; end
    check("rts_dat_low", {31'd0, ps2_dat}, 32'd0);
    cyc(H);
    for (int k = 0; k < n_clocks && k < 10; k++) begin
      dev_clk_low = 1'b1;
      cyc(H);
      dev_clk_low = 1'b0;
      cyc(H);
      bits[k] = ps2_dat;
    end
    if (n_clocks >= 11) begin
      dev_dat_low = 1'b1;
      cyc(H / 2);
      dev_clk_low = 1'b1;
      cyc(H);
      dev_clk_low = 1'b0;
      cyc(H / 2);
      dev_dat_low = 1'b0;
    end
  endtask

  task automatic do_send(input logic [7:0] cmd, input int hold);
    logic [9:0] bits;
    int inh, lows, t;
    exp_tx_q.push_back({1'b1, (($countones(cmd) % 2) == 0), cmd});
    the_command  = cmd;
    send_command = 1'b1;
    dev_host_rx(11, bits, inh);
    check_range("tx_inhibit_len", inh, INH, INH + 1);
    check("tx_frame", {22'd0, bits}, {22'd0, exp_tx_q.pop_front()});
    t = 0;
    while (command_was_sent !== 1'b1 && t < 100) begin cyc(1); t++; end
    check("tx_sent", {31'd0, command_was_sent}, 32'd1);
    check("tx_no_err", {31'd0, error_communication_timed_out}, 32'd0);
    lows = 0;
    for (int i = 0; i < hold; i++) begin
      cyc(1);
      if (ps2_clk === 1'b0) lows++;
    end
    check("tx_no_retrigger", lows, 0);
    check("tx_sent_held", {31'd0, command_was_sent}, 32'd1);
    send_command = 1'b0;
    check("tx_sent_until_edge", {31'd0, command_was_sent}, 32'd1);
    cyc(1);
    check("tx_sent_clear", {30'd0, command_was_sent, error_communication_timed_out}, 32'd0);
    cyc(5);
  endtask

  initial begin
    logic [9:0] bits;
    logic [7:0] d;
    int inh, t, c;
    rst          = 1'b1;
    the_command  = 8'd0;
    send_command = 1'b0;
    dev_clk_low  = 1'b0;
    dev_dat_low  = 1'b0;
    cyc(5);
    check("reset_outputs", {21'd0, received_data, received_data_en, command_was_sent,
                            error_communication_timed_out}, 32'd0);
    check("reset_lines", {30'd0, ps2_clk, ps2_dat}, 32'd3);
    rst = 1'b0;
    cyc(5);

    // Receive: directed frames, then random ones with occasional bad parity/stop
    send_rx(8'hFA, 1'b1, 1'b1);
    send_rx(8'h55, 1'b0, 1'b1);
    send_rx(8'h55, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom_range(0, 255));
      c = $urandom_range(0, 3);
      send_rx(d, ((($countones(d) % 2) == 0) ^ (c == 0)), (c != 1));
    end

    // Partial frame abandoned mid-way must vanish, next frame is clean
    dev_frame({2'b11, 8'h3C, 1'b0}, 4);
    cyc(RX_TO + 50);
    send_rx(8'hA5, 1'b1, 1'b1);

    // Transmit: directed command with long hold, then a random one
    do_send(8'hF4, 2000);
    do_send(8'($urandom_range(0, 255)), 20);

    // Device never clocks: start timeout
    the_command  = 8'($urandom_range(0, 255));
    send_command = 1'b1;
    t = 0;
    while (ps2_clk !== 1'b0 && t < 500) begin cyc(1); t++; end
    while (ps2_clk === 1'b0 && t < 500) begin cyc(1); t++; end
    check_range("start_wait_release", t, 1, 499);
    t = 0;
    while (error_communication_timed_out !== 1'b1 && t < START_TO + 500) begin cyc(1); t++; end
    check_range("start_timeout_cycles", t, START_TO - 2, START_TO + 2);
    check("start_timeout_lines", {30'd0, ps2_clk, ps2_dat}, 32'd3);
    check("start_timeout_not_sent", {31'd0, command_was_sent}, 32'd0);
    send_command = 1'b0;
    cyc(2);
    check("start_timeout_clear", {31'd0, error_communication_timed_out}, 32'd0);
    cyc(5);

    // Device stops after 3 edges: transfer timeout
    the_command  = 8'hFF;
    send_command = 1'b1;
    dev_host_rx(3, bits, inh);
    t = 0;
    while (error_communication_timed_out !== 1'b1 && t < XFER_TO + 500) begin cyc(1); t++; end
    check_range("xfer_timeout_cycles", t, XFER_TO - 3 * 2 * H - 10, XFER_TO);
    check("xfer_timeout_lines", {30'd0, ps2_clk, ps2_dat}, 32'd3);
    check("xfer_timeout_not_sent", {31'd0, command_was_sent}, 32'd0);
    send_command = 1'b0;
    cyc(5);

    // Reset in the middle of the data bits, then a normal command
    the_command  = 8'h00;
    send_command = 1'b1;
    dev_host_rx(3, bits, inh);
    check("tx_bits_dat_driven", {31'd0, ps2_dat}, 32'd0);
    rst = 1'b1;
    #1;
    check("midtx_reset_lines", {30'd0, ps2_clk, ps2_dat}, 32'd3);
    check("midtx_reset_outputs", {21'd0, received_data, received_data_en, command_was_sent,
                                  error_communication_timed_out}, 32'd0);
    last_rx = 8'd0;
    cyc(3);
    rst          = 1'b0;
    send_command = 1'b0;
    cyc(5);
    do_send(8'hF4, 20);

    cyc(50);
    check("rx_queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
